// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport slave  (input  start, funct, op_a, op_b, flush,
                  output busy, done, div_zero, hi, lo, rd_data);
  modport master (output start, funct, op_a, op_b, flush,
                  input  busy, done, div_zero, hi, lo, rd_data);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (shift-add MUL, restoring DIV).
// Optional feature macro: MULDIV_EARLY_OUT_EN (multiply stops once remaining multiplier bits are zero).
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
                         F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               r_state, w_next;
  logic [2*WIDTH-1:0]   r_acc, r_mcand;
  logic [WIDTH-1:0]     r_mplr, r_quo, r_rem, r_dvs, r_hi, r_lo;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg_q, r_neg_r, r_is_div, r_dz, r_done, r_dz_pulse;

  logic                 w_signed, w_is_mul, w_is_div, w_b_zero, w_neg_q, w_neg_r;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_shift, w_diff;
  logic                 w_fits, w_mul_last, w_div_last;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo, w_rem;

  // funct bit 0 distinguishes the unsigned variants (MULTU/DIVU)
  assign w_signed = ~bus.funct[0];
  assign w_is_mul = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
  assign w_is_div = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
  assign w_b_zero = (bus.op_b == '0);
  assign w_abs_a  = (w_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign w_abs_b  = (w_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  assign w_neg_q  = w_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
  assign w_neg_r  = w_signed & bus.op_a[WIDTH-1];

  // Partial remainder never reaches the divisor, so W bits hold it; the guard bit lives in the trial subtract.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_diff[WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
  assign w_mul_last = (r_cnt == CW'(WIDTH-1)) || (r_mplr[WIDTH-1:1] == '0);
`else
  assign w_mul_last = (r_cnt == CW'(WIDTH-1));
`endif
  assign w_div_last = (r_cnt == CW'(WIDTH-1));

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_quo : r_quo;
  assign w_rem  = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && w_is_mul) w_next = S_MUL;
          else if (bus.start && w_is_div) w_next = w_b_zero ? S_FIX : S_DIV;
        end
        S_MUL:   if (w_mul_last) w_next = S_FIX;
        S_DIV:   if (w_div_last) w_next = S_FIX;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0; r_mcand <= '0; r_mplr <= '0; r_quo <= '0; r_rem <= '0; r_dvs <= '0;
      r_hi <= '0; r_lo <= '0; r_cnt <= '0;
      r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_is_div <= 1'b0; r_dz <= 1'b0;
      r_done <= 1'b0; r_dz_pulse <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_dz_pulse <= 1'b0;
      if (!bus.flush) begin
        case (r_state)
          S_IDLE: if (bus.start) begin
            if (w_is_mul) begin
              r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
              r_mplr   <= w_abs_b;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_neg_q  <= w_neg_q;
              r_is_div <= 1'b0;
              r_dz     <= 1'b0;
            end else if (w_is_div) begin
              // on a zero divisor the raw dividend is parked in r_quo for HI
              r_quo    <= w_b_zero ? bus.op_a : w_abs_a;
              r_dvs    <= w_abs_b;
              r_rem    <= '0;
              r_cnt    <= '0;
              r_neg_q  <= w_neg_q;
              r_neg_r  <= w_neg_r;
              r_is_div <= 1'b1;
              r_dz     <= w_b_zero;
            end else if (bus.funct == F_MTHI) begin
              r_hi <= bus.op_a;
            end else if (bus.funct == F_MTLO) begin
              r_lo <= bus.op_a;
            end
          end
          S_MUL: begin
            if (r_mplr[0]) r_acc <= r_acc + r_mcand;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + 1'b1;
          end
          S_DIV: begin
            r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
            r_cnt <= r_cnt + 1'b1;
          end
          default: begin
            if (r_dz) begin
              r_hi <= r_quo;
              r_lo <= '1;
            end else if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
            r_done     <= 1'b1;
            r_dz_pulse <= r_dz;
          end
        endcase
      end
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz_pulse;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.rd_data  = (bus.funct == F_MFHI) ? r_hi :
                        (bus.funct == F_MFLO) ? r_lo : '0;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the execute stage of the MIPS pipeline. It is the parametrised successor of the combinational ALU-control decoder. It decodes the R-type funct codes that decoder leaves unhandled: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. It runs each multiply or divide as a multi-cycle sequence and raises `busy` so the hazard unit can stall dependent instructions.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be even and at least 4.
- `clk`  in  1  — clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `start`  in  1  — request valid; sampled only in IDLE.
- `funct`  in  6  — R-type function field: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU, 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO.
- `op_a`  in  WIDTH  — rs value: multiplicand, dividend, or MTHI/MTLO source.
- `op_b`  in  WIDTH  — rt value: multiplier or divisor.
- `flush`  in  1  — abort any in-flight operation.
- `busy`  out  1  — multiply/divide in progress.
- `done`  out  1  — one-cycle pulse; HI/LO hold a new mult/div result.
- `div_zero`  out  1  — one-cycle pulse alongside `done` when the divisor was 0.
- `hi`  out  WIDTH  — HI register.
- `lo`  out  WIDTH  — LO register.
- `rd_data`  out  WIDTH  — combinational: `hi` when `funct`=MFHI, `lo` when `funct`=MFLO, otherwise 0.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE with `start`=1 and `funct`=MULT/MULTU:
  - latch the operands (absolute values for MULT, with the result sign = sign(a) XOR sign(b));
  - clear the accumulator and iteration counter; go to MUL.
- IDLE with `start`=1 and `funct`=DIV/DIVU: same latching for DIV, with quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a); go to DIV.
- IDLE with `start`=1 and `funct`=MTHI/MTLO: `hi` or `lo` is loaded with `op_a` at that edge; state stays IDLE.
- MFHI/MFLO and unlisted funct codes cause no state change.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator; after WIDTH iterations go to FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH-bit partial remainder plus one guard bit; after WIDTH iterations go to FIX.
- FIX:
  - apply the two's-complement sign correction;
  - write `hi` = product[2W-1:W] or remainder, and `lo` = product[W-1:0] or quotient;
  - pulse `done`; return to IDLE.
- Divide by zero: skips the iterations (DIV goes to FIX directly).
  - Result: `lo` = all ones, `hi` = `op_a` (unsigned or signed, unchanged), and `div_zero` pulses with `done`.
- `start` while `busy`=1 is ignored. The pipeline must hold the instruction until `busy`=0.
- `flush`: in any state, returns to IDLE at the next edge.
  - `hi`/`lo` are unchanged and no `done` is produced.
  - `flush` has priority over `start` in the same cycle.
- Signed overflow (−2^(W−1) / −1) gives `lo` = −2^(W−1) and `hi` = 0, with no flag.

## Timing
- Reset values: state IDLE; `busy`, `done` and `div_zero` are 0; `hi` and `lo` are 0; internal counters and accumulators are 0.
- Assertion of `rst_n` mid-operation aborts immediately and asynchronously.
- Accept edge E0. `busy` is 1 from E0 through the FIX cycle, which is WIDTH+1 cycles without early-out.
- `hi`, `lo`, `done` and `div_zero` update at edge E0+WIDTH+1. `busy` is 0 in that same cycle.
- A new `start` is accepted on that same cycle, giving back-to-back throughput of one op per WIDTH+1 cycles.
- Divide by zero: the result is visible at E0+1 and `busy` lasts exactly 1 cycle.
- MTHI/MTLO: a 1-cycle write with no `busy`.
- `rd_data` has zero latency and reflects the current registers. MFHI in the `done` cycle returns the new value.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: MUL goes to FIX as soon as the remaining unshifted multiplier bits are all zero, with a minimum of 1 iteration.
  - Multiply latency becomes (index of highest set bit of |op_b|)+2 cycles.
  - DIV is unaffected.
- `MULDIV_EARLY_OUT_EN` undefined: multiply always takes exactly WIDTH iterations.

## Test plan
All scenarios use WIDTH=32 with `MULDIV_EARLY_OUT_EN` undefined unless stated otherwise.
- MULTU 0xFFFFFFFF × 0x00000002 -> `done` at E0+33; `hi`=0x00000001, `lo`=0xFFFFFFFE; `busy` high for exactly 33 cycles.
- MULT −3 × 5, then back-to-back DIV −7 / 2 issued in the `done` cycle:
  - after the MULT: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1;
  - after the DIV: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 0x1234 / 0 -> at E0+1, `done`=1, `div_zero`=1, `lo`=0xFFFFFFFF, `hi`=0x00001234.
- MULTU 0x10 × 0x10 on a build with `MULDIV_EARLY_OUT_EN` defined -> `done` at E0+6, `hi`=0, `lo`=0x100.
- MTHI 0xA5A5A5A5, then MFHI -> `rd_data`=0xA5A5A5A5 one cycle later. A further `start` with MULTU while `busy` is ignored, so `hi`/`lo` show only the first result.
- Flush and reset mid-operation:
  - DIV started with `hi`/`lo` preloaded to 0x11/0x22; `flush` at E0+10 -> `busy`=0 at E0+11, no `done`, `hi`/`lo` still 0x11/0x22.
  - Repeat with `rst_n` low at E0+10 -> all outputs 0 immediately.
